// File: rtl/stream_byte_packer.sv
// stream_byte_packer: packs a serial bit stream MSB-first into bytes and
// buffers them in a small FIFO with a valid/ready output and a drop counter.
// Ports: clk, rst (sync, active-high), en, data_in (serial bit),
//        byte_out/byte_valid/byte_ready (output stream), drop_count.
// Option: define VN_DEBIAS_EN to insert a von Neumann debiaser before packing.
module stream_byte_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  data_in,
    output logic [7:0]            byte_out,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic            acc_valid;
    logic            acc_bit;

`ifdef VN_DEBIAS_EN
    typedef enum logic {
        WAIT_FIRST,
        WAIT_SECOND
    } pair_state_t;

    pair_state_t state_q, state_d;
    logic        first_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_FIRST;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (en && state_q == WAIT_FIRST)
                first_q <= data_in;
        end
    end

    // Unequal pairs emit the first bit of the pair; equal pairs emit nothing.
    always_comb begin
        state_d   = state_q;
        acc_valid = 1'b0;
        acc_bit   = 1'b0;
        if (en) begin
            unique case (state_q)
                WAIT_FIRST: begin
                    state_d = WAIT_SECOND;
                end
                WAIT_SECOND: begin
                    state_d   = WAIT_FIRST;
                    acc_valid = first_q ^ data_in;
                    acc_bit   = first_q;
                end
                default: state_d = WAIT_FIRST;
            endcase
        end
    end
`else
    always_comb begin
        acc_valid = en;
        acc_bit   = data_in;
    end
`endif

    // Only seven bits are stored; the eighth completes the byte directly.
    logic [6:0]            shift_q;
    logic [2:0]            bit_cnt_q;
    logic [7:0]            mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [DROP_CNT_W-1:0] drop_q;

    logic       push;
    logic [7:0] push_byte;
    logic       pop;
    logic       full;
    logic       wr_en;
    logic       drop;

    always_comb begin
        push      = acc_valid && (bit_cnt_q == 3'd7);
        push_byte = {shift_q, acc_bit};
        full      = (count_q == CW'(FIFO_DEPTH));
        pop       = byte_valid && byte_ready;
        // A full FIFO still accepts a push when the head leaves this edge.
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (acc_valid) begin
            shift_q   <= {shift_q[5:0], acc_bit};
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem[wr_ptr_q] <= push_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_en && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !wr_en)
                count_q <= count_q - CW'(1);
            if (drop && !(&drop_q))
                drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end

    assign byte_valid = (count_q != '0);
    assign byte_out   = byte_valid ? mem[rd_ptr_q] : 8'h00;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed bench for stream_byte_packer with a byte scoreboard queue.
module tb_stream_byte_packer;

    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          data_in = 1'b0;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready = 1'b0;
    logic [DW-1:0] drop_count;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q [$];

    stream_byte_packer #(.FIFO_DEPTH(4), .DROP_CNT_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .data_in(data_in),
        .byte_out(byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a transfer happens at the next edge whenever valid&ready.
    always @(negedge clk) begin
        if (!rst && byte_valid === 1'b1 && byte_ready === 1'b1) begin
            check("unexpected_byte", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("byte_out", 32'(byte_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        en      = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
        en      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            send_bit(b[i]);
    endtask

    task automatic drain(input string tag);
        byte_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            idle(1);
        idle(1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid_low"}, 32'(byte_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'h00);
        check("rst_drop", 32'(drop_count), 32'd0);
        byte_ready = 1'b1;
        idle(3);
        check("ready_empty_valid", 32'(byte_valid), 32'd0);

`ifdef VN_DEBIAS_EN
        exp_q.push_back(8'hB1);
        send_bit(1); send_bit(0);
        send_bit(0); send_bit(1);
        send_bit(1); idle(3); send_bit(1);
        send_bit(0); send_bit(0);
        send_bit(1); send_bit(0);
        send_bit(1); send_bit(0);
        check("vn_no_early_valid", 32'(byte_valid), 32'd0);
        send_bit(0); send_bit(1);
        send_bit(0); send_bit(1);
        send_bit(0); send_bit(1);
        check("vn_partial_valid", 32'(byte_valid), 32'd0);
        send_bit(1); send_bit(0);
        check("vn_valid", 32'(byte_valid), 32'd1);
        drain("vn");
        check("vn_drop", 32'(drop_count), 32'd0);
`else
        // Basic byte, valid for exactly one cycle.
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        check("a5_valid", 32'(byte_valid), 32'd1);
        idle(1);
        check("a5_valid_one_cycle", 32'(byte_valid), 32'd0);
        check("a5_drop", 32'(drop_count), 32'd0);

        // Partial byte held across an en=0 pause.
        exp_q.push_back(8'hC1);
        send_bit(1); send_bit(1); send_bit(0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("pause_valid", 32'(byte_valid), 32'd0);
        end
        send_bit(0); send_bit(0); send_bit(0); send_bit(0);
        check("pause_partial", 32'(byte_valid), 32'd0);
        send_bit(1);
        check("c1_valid", 32'(byte_valid), 32'd1);
        drain("c1");

        // Backpressure: four buffered, two dropped.
        byte_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            b = 8'(i);
            if (i <= 4)
                exp_q.push_back(b);
            send_byte(b);
        end
        check("bp_drop", 32'(drop_count), 32'd2);
        check("bp_valid", 32'(byte_valid), 32'd1);
        check("bp_head", 32'(byte_out), 32'h01);
        idle(2);
        check("bp_head_stable", 32'(byte_out), 32'h01);
        drain("bp");

        // Full FIFO with a pop on the completing edge.
        byte_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b = 8'h10 + 8'(i);
            exp_q.push_back(b);
            send_byte(b);
        end
        exp_q.push_back(8'h14);
        b = 8'h14;
        for (int i = 7; i >= 1; i--)
            send_bit(b[i]);
        byte_ready = 1'b1;
        send_bit(b[0]);
        byte_ready = 1'b0;
        check("fullpop_drop", 32'(drop_count), 32'd2);
        check("fullpop_head", 32'(byte_out), 32'h11);
        send_byte(8'h15);
        check("still_full_drop", 32'(drop_count), 32'd3);
        for (int i = 0; i < 4; i++)
            send_byte(8'h20 + 8'(i));
        check("drop_at_max", 32'(drop_count), 32'd7);
        send_byte(8'h30);
        check("drop_saturate", 32'(drop_count), 32'd7);
        drain("fullpop");

        // Reset mid-byte.
        byte_ready = 1'b1;
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        rst     = 1'b1;
        en      = 1'b1;
        data_in = 1'b1;
        idle(1);
        rst = 1'b0;
        en  = 1'b0;
        check("midrst_drop", 32'(drop_count), 32'd0);
        check("midrst_valid", 32'(byte_valid), 32'd0);
        check("midrst_byte_out", 32'(byte_out), 32'h00);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        check("3c_valid", 32'(byte_valid), 32'd1);
        drain("3c");
        check("3c_drop", 32'(drop_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
